snn_lif_layer: RTL and testbench



---
 rtl/snn_pkg.sv | 37 +++
 rtl/snn_lif_unit.sv | 81 ++++++++
 rtl/snn_lif_layer.sv | 110 +++++++++++
 tb/tb_snn_lif_layer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and arithmetic helpers for the binary SNN layer.
// Holds the layer FSM state encoding and a saturating clamp. Callers do
// their arithmetic at CALC_W bits and clamp the result to the
// accumulator range.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // CALC_W is wide enough that a three-way sum of accumulator-range
    // values can never wrap before it is clamped.
    localparam int CALC_W = 40;

    // Clamp v to the signed range of an acc_width-bit register.
    function automatic logic signed [CALC_W-1:0] sat_clip(
        input logic signed [CALC_W-1:0] v,
        input int                       acc_width
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        one = 1;
        hi  = (one <<< acc_width - 1) - one;
        lo  = -hi - one;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/snn_lif_unit.sv
// snn_lif_unit: one integrate-and-fire neuron.
// It accumulates the selected signed weight during the input scan. On the
// fire cycle it folds the accumulator, the bias and the optional leak into
// the membrane and applies a soft reset when the membrane fires.
// Build option: define SNN_LEAK_EN to subtract vmem >>> LEAK_SHIFT on every
// fire cycle. Without it the neuron is a pure integrator.
module snn_lif_unit
    import snn_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int ACC_WIDTH  = 12,
    parameter int THRESHOLD  = 8,
    parameter int LEAK_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_clear,
    input  logic                 vmem_clear,
    input  logic                 acc_en,
    input  logic                 fire,
    input  logic [WIDTH-1:0]     weight,
    input  logic [WIDTH-1:0]     bias,
    output logic                 spike,
    output logic [ACC_WIDTH-1:0] vmem
);

`ifdef SNN_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic [ACC_WIDTH-1:0]     acc;
    logic signed [CALC_W-1:0] acc_ext;
    logic signed [CALC_W-1:0] vmem_ext;
    logic signed [CALC_W-1:0] weight_ext;
    logic signed [CALC_W-1:0] bias_ext;
    logic signed [CALC_W-1:0] leak_ext;
    logic signed [CALC_W-1:0] acc_sum;
    logic signed [CALC_W-1:0] v_sat;
    logic signed [CALC_W-1:0] thr_ext;
    logic                     fire_hit;
    logic [ACC_WIDTH-1:0]     vmem_next;

    // Sign-extend the operands, then form the saturated accumulate and fire results.
    always_comb begin
        acc_ext    = CALC_W'($signed(acc));
        vmem_ext   = CALC_W'($signed(vmem));
        weight_ext = CALC_W'($signed(weight));
        bias_ext   = CALC_W'($signed(bias));
        thr_ext    = CALC_W'(THRESHOLD);
        acc_sum    = sat_clip(acc_ext + weight_ext, ACC_WIDTH);
        leak_ext   = LEAK_ON ? (vmem_ext >>> LEAK_SHIFT) : '0;
        v_sat      = sat_clip(vmem_ext + acc_ext + bias_ext - leak_ext, ACC_WIDTH);
        fire_hit   = (v_sat >= thr_ext);
        vmem_next  = fire_hit ? ACC_WIDTH'(v_sat - thr_ext) : ACC_WIDTH'(v_sat);
    end

    // Hold the accumulator, the membrane and the spike. A clear takes effect before a start on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            vmem  <= '0;
            spike <= 1'b0;
        end else begin
            if (vmem_clear) begin
                vmem  <= '0;
                spike <= 1'b0;
            end
            if (acc_clear)
                acc <= '0;
            else if (acc_en)
                acc <= ACC_WIDTH'(acc_sum);
            if (fire) begin
                vmem  <= vmem_next;
                spike <= fire_hit;
            end
        end
    end

endmodule

// File: rtl/snn_lif_layer.sv
// snn_lif_layer: a layer of NUM_NEURONS integrate-and-fire neurons.
// A shared FSM scans the latched input spikes one per cycle and the
// neurons fire together. The handshake is start/busy/done.
// Build option: SNN_LEAK_EN enables the membrane leak inside every
// snn_lif_unit.
module snn_lif_layer
    import snn_pkg::*;
#(
    parameter int IN_SIZE     = 4,
    parameter int NUM_NEURONS = 2,
    parameter int WIDTH       = 4,
    parameter int ACC_WIDTH   = 12,
    parameter int THRESHOLD   = 8,
    parameter int LEAK_SHIFT  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             vmem_clear,
    input  logic [IN_SIZE-1:0]               in_spikes,
    input  logic [NUM_NEURONS*IN_SIZE*WIDTH-1:0] weight,
    input  logic [NUM_NEURONS*WIDTH-1:0]     bias,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_NEURONS-1:0]           spike_out,
    output logic [NUM_NEURONS*ACC_WIDTH-1:0] vmem_out
);

    localparam int AW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(IN_SIZE - 1);

    state_t             state;
    logic [AW-1:0]      addr;
    logic [IN_SIZE-1:0] spikes_q;
    logic               acc_clear;
    logic               clear_now;
    logic               acc_en;
    logic               fire;

    // Decode the per-neuron strobes from the FSM state.
    always_comb begin
        acc_clear = (state == IDLE) && start;
        clear_now = (state == IDLE) && vmem_clear;
        acc_en    = (state == ACCUM) && spikes_q[addr];
        fire      = (state == FIRE);
    end

    // Step the FSM through the input scan, with registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            spikes_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        spikes_q <= in_spikes;
                        addr     <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (addr == ADDR_LAST)
                        state <= FIRE;
                    else
                        addr <= addr + 1'b1;
                end
                FIRE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_neuron
        logic [WIDTH-1:0] w_sel;
        assign w_sel = weight[(n*IN_SIZE + int'(addr))*WIDTH +: WIDTH];

        snn_lif_unit #(
            .WIDTH      (WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .THRESHOLD  (THRESHOLD),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_unit (
            .clk        (clk),
            .reset      (reset),
            .acc_clear  (acc_clear),
            .vmem_clear (clear_now),
            .acc_en     (acc_en),
            .fire       (fire),
            .weight     (w_sel),
            .bias       (bias[n*WIDTH +: WIDTH]),
            .spike      (spike_out[n]),
            .vmem       (vmem_out[n*ACC_WIDTH +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
// tb_snn_lif_layer: directed checks of snn_lif_layer. Instance u_dut uses the
// default parameters. Instance u_sat is a one-neuron layer with ACC_WIDTH=6
// and THRESHOLD=31; it covers saturation and the leak cases.
module tb_snn_lif_layer;

`ifdef SNN_LEAK_EN
    localparam bit LEAK = 1'b1;
`else
    localparam bit LEAK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, vmem_clear;
    logic [3:0]  in_spikes;
    logic [31:0] weight;
    logic [7:0]  bias;
    logic        busy, done;
    logic [1:0]  spike_out;
    logic [23:0] vmem_out;

    logic        b_reset, b_start, b_vmem_clear;
    logic [3:0]  b_in_spikes;
    logic [15:0] b_weight;
    logic [3:0]  b_bias;
    logic        b_busy, b_done;
    logic [0:0]  b_spike_out;
    logic [5:0]  b_vmem_out;

    int checks = 0;
    int errors = 0;
    int lat;
    int dcount;

    always #5 clk = ~clk;

    snn_lif_layer u_dut (
        .clk(clk), .reset(reset), .start(start), .vmem_clear(vmem_clear),
        .in_spikes(in_spikes), .weight(weight), .bias(bias),
        .busy(busy), .done(done), .spike_out(spike_out), .vmem_out(vmem_out)
    );

    snn_lif_layer #(.IN_SIZE(4), .NUM_NEURONS(1), .WIDTH(4), .ACC_WIDTH(6),
                    .THRESHOLD(31), .LEAK_SHIFT(2)) u_sat (
        .clk(clk), .reset(b_reset), .start(b_start), .vmem_clear(b_vmem_clear),
        .in_spikes(b_in_spikes), .weight(b_weight), .bias(b_bias),
        .busy(b_busy), .done(b_done), .spike_out(b_spike_out), .vmem_out(b_vmem_out)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start (optionally with vmem_clear) and count cycles until done.
    task automatic run_a(input logic clr, output int cycles);
        @(negedge clk);
        start = 1'b1;
        vmem_clear = clr;
        cycles = 0;
        @(negedge clk);
        start = 1'b0;
        vmem_clear = 1'b0;
        cycles = 1;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_b(output int cycles);
        @(negedge clk);
        b_start = 1'b1;
        cycles = 0;
        @(negedge clk);
        b_start = 1'b0;
        cycles = 1;
        while (!b_done && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; vmem_clear = 1'b0;
        in_spikes = '0; weight = '0; bias = '0;
        b_reset = 1'b1; b_start = 1'b0; b_vmem_clear = 1'b0;
        b_in_spikes = '0; b_weight = '0; b_bias = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        b_reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_spike", 32'(spike_out), 0);
        chk("reset_vmem", 32'(vmem_out), 0);

        // Neuron0: weights +3 and bias 0. Neuron1: weights -2 and bias +1. All inputs spike.
        in_spikes = 4'b1111;
        weight = 32'hEEEE_3333;
        bias = 8'h10;
        run_a(1'b0, lat);
        chk("t1_latency", lat, 6);
        chk("t1_busy_at_done", 32'(busy), 1);
        chk("t1_spike0", 32'(spike_out[0]), 1);
        chk("t1_vmem0", $signed(vmem_out[11:0]), 4);
        chk("t1_spike1", 32'(spike_out[1]), 0);
        chk("t1_vmem1", $signed(vmem_out[23:12]), -7);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_busy_after", 32'(busy), 0);

        // Inputs 0 and 2 spike. Neuron1 ends at -7-4+1 = -10, or -8 with leak (-7>>>2 = -2).
        in_spikes = 4'b0101;
        run_a(1'b0, lat);
        chk("t2_vmem1", $signed(vmem_out[23:12]), LEAK ? -8 : -10);
        chk("t2_vmem0", $signed(vmem_out[11:0]), LEAK ? 1 : 2);

        // Reset in the middle of ACCUM discards the timestep.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_spike", 32'(spike_out), 0);
        chk("rst_vmem", 32'(vmem_out), 0);
        reset = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("rst_no_done", dcount, 0);

        // A start during ACCUM (k=2) and during FIRE (k=5) must be dropped.
        in_spikes = 4'b0001;
        dcount = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcount++;
            start = (k == 0 || k == 2 || k == 5);
        end
        start = 1'b0;
        chk("ign_done_count", dcount, 1);
        chk("ign_vmem0", $signed(vmem_out[11:0]), 3);
        chk("ign_vmem1", $signed(vmem_out[23:12]), -1);

        // vmem_clear on its own, then a timestep that leaves vmem0 at 5.
        @(negedge clk);
        vmem_clear = 1'b1;
        @(negedge clk);
        vmem_clear = 1'b0;
        chk("clr_vmem", 32'(vmem_out), 0);
        bias = 8'h12;
        run_a(1'b0, lat);
        chk("pre_vmem0", $signed(vmem_out[11:0]), 5);
        // start together with vmem_clear: the timestep begins from 0, so vmem0 is 5 again and there is no spike.
        run_a(1'b1, lat);
        chk("clrstart_vmem0", $signed(vmem_out[11:0]), 5);
        chk("clrstart_spike0", 32'(spike_out[0]), 0);

        // Narrow layer: 28 + 7 = 35 saturates to 31, fires, soft reset gives 0.
        b_in_spikes = 4'b1111;
        b_weight = 16'h7777;
        b_bias = 4'h7;
        run_b(lat);
        chk("sat_latency", lat, 6);
        chk("sat_spike", 32'(b_spike_out), 1);
        chk("sat_vmem", $signed(b_vmem_out), 0);
        // Build the membrane up to 16 (below 31), then run an idle timestep.
        b_weight = 16'h4444;
        b_bias = 4'h0;
        run_b(lat);
        chk("leak_pre_vmem", $signed(b_vmem_out), 16);
        b_in_spikes = 4'b0000;
        run_b(lat);
        chk("leak_vmem", $signed(b_vmem_out), LEAK ? 12 : 16);
        chk("leak_spike", 32'(b_spike_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
